// File: rtl/usb_rx_decoder_if.sv
// ---------------------------------------------------------------------------
// usb_rx_decoder_if
// Bundles the USB line inputs and the decoded-packet outputs of the receive
// decoder.
//   d_plus, d_minus : USB differential pair, already synchronized to clk
//   rcv_data        : last completed byte, bit0 = first bit received
//   byte_valid      : one-cycle strobe, rcv_data valid in that cycle
//   rcving          : packet in progress (SYNC start to EOP or error)
//   eop_detected    : one-cycle strobe on a legal end-of-packet
//   rcv_error       : sticky protocol error flag, cleared at next SYNC start
// master = line driver / packet consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface usb_rx_decoder_if;
  logic       d_plus;
  logic       d_minus;
  logic [7:0] rcv_data;
  logic       byte_valid;
  logic       rcving;
  logic       eop_detected;
  logic       rcv_error;

  modport master (
    output d_plus, d_minus,
    input  rcv_data, byte_valid, rcving, eop_detected, rcv_error
  );

  modport slave (
    input  d_plus, d_minus,
    output rcv_data, byte_valid, rcving, eop_detected, rcv_error
  );
endinterface

// File: rtl/usb_rx_decoder.sv
// ---------------------------------------------------------------------------
// usb_rx_decoder
// Oversampling USB receive decoder: bit-timing recovery from d_plus edges,
// NRZI decode, bit unstuffing, SYNC check, EOP detection and LSB-first byte
// assembly.
// Ports:
//   clk    : system clock, rising edge
//   n_rst  : asynchronous active-low reset
//   bus    : usb_rx_decoder_if.slave (line in, decoded bytes/status out)
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | bus idle, waiting for a J->K edge on the line
// SYNC     | collecting the 8 SYNC bits, must decode to 8'h80
// RECEIVE  | assembling data bytes, SE0 at a byte boundary starts EOP
// EOP_WAIT | expecting a second SE0 sample, then a J sample
// ERROR    | protocol error, waiting for 8 consecutive J samples
// ---------------------------------------------------------------------------
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  usb_rx_decoder_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    RECEIVE  = 3'd2,
    EOP_WAIT = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          dp_last_q, dp_last_d;
  logic          prev_q, prev_d;
  logic [2:0]    ones_q, ones_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rcv_data_q, rcv_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;
  logic          se0_seen_q, se0_seen_d;

  logic sample;
  logic line_j, line_k, line_se0, line_se1;
  logic dec_bit;
  logic enter_err;

  assign line_j   =  bus.d_plus & ~bus.d_minus;
  assign line_k   = ~bus.d_plus &  bus.d_minus;
  assign line_se0 = ~bus.d_plus & ~bus.d_minus;
  assign line_se1 =  bus.d_plus &  bus.d_minus;
  assign sample   = (phase_q == CW'(SAMPLE_POINT));
  // NRZI: no change on d_plus between samples means a 1
  assign dec_bit  = (bus.d_plus == prev_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      dp_last_q    <= 1'b1;
      prev_q       <= 1'b1;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rcv_data_q   <= '0;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
      se0_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      dp_last_q    <= dp_last_d;
      prev_q       <= prev_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rcv_data_q   <= rcv_data_d;
      byte_valid_q <= byte_valid_d;
      eop_q        <= eop_d;
      err_q        <= err_d;
      se0_seen_q   <= se0_seen_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dp_last_d    = bus.d_plus;
    prev_d       = prev_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rcv_data_d   = rcv_data_q;
    byte_valid_d = 1'b0;
    eop_d        = 1'b0;
    err_d        = err_q;
    se0_seen_d   = se0_seen_q;
    enter_err    = 1'b0;

    // Phase counter, resynchronized on every d_plus edge
    if (phase_q == CW'(CLKS_PER_BIT - 1)) phase_d = '0;
    else                                  phase_d = phase_q + CW'(1);
    if (bus.d_plus != dp_last_q) phase_d = '0;

    // SE0 carries no NRZI level, so it must not disturb the reference
    if (sample && !line_se0) prev_d = bus.d_plus;

    case (state_q)
      IDLE: begin
        if (dp_last_q && line_k) begin
          state_d   = SYNC;
          phase_d   = '0;
          bit_cnt_d = '0;
          ones_d    = '0;
          err_d     = 1'b0;
          // the K sample itself must decode against J
          prev_d    = 1'b1;
        end
      end

      SYNC, RECEIVE: begin
        if (sample) begin
          if (line_se1 || (line_se0 && state_q == SYNC)) begin
            enter_err = 1'b1;
          end else if (line_se0) begin
            if (bit_cnt_q == 3'd0) begin
              state_d    = EOP_WAIT;
              se0_seen_d = 1'b0;
            end else begin
              enter_err = 1'b1;
            end
          end else if (ones_q == 3'd6) begin
            // stuff-bit slot: a 0 is dropped, a 1 is a stuffing violation
            if (dec_bit) enter_err = 1'b1;
            else         ones_d    = '0;
          end else begin
            ones_d    = dec_bit ? (ones_q + 3'd1) : 3'd0;
            shift_d   = {dec_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == SYNC) begin
                if (shift_d == 8'h80) state_d   = RECEIVE;
                else                  enter_err = 1'b1;
              end else begin
                rcv_data_d   = shift_d;
                byte_valid_d = 1'b1;
              end
            end
          end
        end
      end

      EOP_WAIT: begin
        if (sample) begin
          if (!se0_seen_q) begin
            if (line_se0) se0_seen_d = 1'b1;
            else          enter_err  = 1'b1;
          end else if (line_j) begin
            eop_d   = 1'b1;
            prev_d  = 1'b1;
            state_d = IDLE;
          end else begin
            enter_err = 1'b1;
          end
        end
      end

      ERROR: begin
        // bit_cnt doubles as the consecutive-J counter here
        if (sample) begin
          if (line_j) begin
            if (bit_cnt_q == 3'd7) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            bit_cnt_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (enter_err) begin
      state_d      = ERROR;
      err_d        = 1'b1;
      bit_cnt_d    = '0;
      byte_valid_d = 1'b0;
      rcv_data_d   = rcv_data_q;
    end
  end

  assign bus.rcv_data     = rcv_data_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.eop_detected = eop_q;
  assign bus.rcv_error    = err_q;
  assign bus.rcving       = (state_q == SYNC) || (state_q == RECEIVE) ||
                            (state_q == EOP_WAIT);

endmodule
